// File: rtl/qspi_pkg.sv
// qspi_pkg: opcodes and responder state encoding shared by the QSPI flash
// responder and the controller-side command builders.
//   READ/QOFR/PP/RDSR/RDID/WREN/WRDI : SPI NOR opcode bytes
//   state_t                          : responder protocol states
//   status_byte()                    : status register image from WEL
package qspi_pkg;

  localparam logic [7:0] READ = 8'h03;  // single-line read
  localparam logic [7:0] QOFR = 8'h6B;  // quad output fast read
  localparam logic [7:0] PP   = 8'h02;  // page program
  localparam logic [7:0] RDSR = 8'h05;  // read status register
  localparam logic [7:0] RDID = 8'h9F;  // read JEDEC ID
  localparam logic [7:0] WREN = 8'h06;  // write enable
  localparam logic [7:0] WRDI = 8'h04;  // write disable

  localparam int DUMMY_CLKS = 8;        // dummy clocks before quad data

  typedef enum logic [3:0] {
    IDLE, CMD, ADDR, DUMMY, RDATA, QDATA, WDATA, STATUS, ID, IGNORE
  } state_t;

  // WIP is never set: programs complete instantly in the RAM model.
  function automatic logic [7:0] status_byte(input logic wel);
    return {6'b0, wel, 1'b0};
  endfunction

endpackage

// File: rtl/qspi_resp_mem.sv
// qspi_resp_mem: DEPTH x 8 single-port synchronous RAM standing in for the
// flash array. Read-first, one cycle read latency, contents not reset.
//   clk   : system clock
//   we    : write strobe, wdata stored at addr
//   addr  : byte address (read every cycle)
//   wdata : write byte
//   rdata : mem[addr] as of the previous cycle
module qspi_resp_mem #(
  parameter  int DEPTH = 4096,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/qspi_flash_responder.sv
// qspi_flash_responder: answers the QSPI controller like a small SPI NOR
// flash, oversampling C/S/DQ on the system clock (SPI mode 0).
//   clk   : system clock
//   reset : synchronous, active-high
//   C     : SPI clock from the initiator, idles low
//   S     : chip select, active-low
//   DQio  : DQ0 = MOSI, DQ1 = MISO, all four outputs in quad read;
//           released (high-Z) whenever not driven
// Params: DEPTH (array bytes, power of two), JEDEC_ID (read-ID bytes).
module qspi_flash_responder
  import qspi_pkg::*;
#(
  parameter int          DEPTH    = 4096,
  parameter logic [23:0] JEDEC_ID = 24'h20BA18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       S,
  inout  wire  [3:0] DQio
);

  localparam int AW = $clog2(DEPTH);

  // Pin synchronizers. Left out of reset so a reset taken while S is low
  // does not fabricate an S edge. DQ2/DQ3 are never inputs.
  logic [1:0] c_sync, s_sync, dq0_sync;
  logic       c_prev, s_prev;

  always_ff @(posedge clk) begin
    c_sync   <= {c_sync[0], C};
    s_sync   <= {s_sync[0], S};
    dq0_sync <= {dq0_sync[0], DQio[0]};
    c_prev   <= c_sync[1];
    s_prev   <= s_sync[1];
  end

  logic c_rise, c_fall, s_rise, s_fall, dq0;
  assign c_rise = c_sync[1] & ~c_prev;
  assign c_fall = ~c_sync[1] & c_prev;
  assign s_rise = s_sync[1] & ~s_prev;
  assign s_fall = ~s_sync[1] & s_prev;
  assign dq0    = dq0_sync[1];

  state_t        state, state_n;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_cnt;   // address byte index, or ID byte index
  logic [6:0]    sh_in;
  logic [7:0]    sh_out;     // output shift register; its MSBs are the pins
  logic [7:0]    op;
  logic [AW-1:0] addr, addr_page;
  logic          wel;
  logic          extra;      // a bit arrived after the 8-bit opcode
  logic [7:0]    cmd_byte, out_byte, mem_rdata;
  logic          mem_we;
  logic [3:0]    dq_oe, dq_out;

  assign cmd_byte = {sh_in, dq0};

  qspi_resp_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .addr  (addr),
    .wdata (cmd_byte),
    .rdata (mem_rdata)
  );

  // Program address advances within the 256-byte page only.
  always_comb begin
    addr_page      = addr;
    addr_page[7:0] = addr[7:0] + 8'd1;
  end

  always_comb begin
    out_byte = mem_rdata;
    case (state)
      STATUS: out_byte = status_byte(wel);
      ID: begin
        case (byte_cnt)
          2'd0:    out_byte = JEDEC_ID[23:16];
          2'd1:    out_byte = JEDEC_ID[15:8];
          2'd2:    out_byte = JEDEC_ID[7:0];
          default: out_byte = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    dq_oe   = 4'b0000;
    dq_out  = {2'b00, sh_out[7], 1'b0};
    // Combinational strobe so a byte finishing on the same clk as S rising
    // still lands in memory.
    mem_we  = (state == WDATA) && c_rise && (bit_cnt == 3'd7) && !reset;

    case (state)
      IDLE: if (s_fall) state_n = CMD;
      CMD: begin
        if (c_rise && bit_cnt == 3'd7) begin
          case (cmd_byte)
            READ, QOFR: state_n = ADDR;
            PP:         state_n = wel ? ADDR : IGNORE;
            RDSR:       state_n = STATUS;
            RDID:       state_n = ID;
            default:    state_n = IGNORE;
          endcase
        end
      end
      ADDR: begin
        if (c_rise && bit_cnt == 3'd7 && byte_cnt == 2'd2) begin
          if (op == QOFR)    state_n = DUMMY;
          else if (op == PP) state_n = WDATA;
          else               state_n = RDATA;
        end
      end
      DUMMY: if (c_rise && bit_cnt == 3'(DUMMY_CLKS - 1)) state_n = QDATA;
      RDATA, STATUS, ID: dq_oe = 4'b0010;
      QDATA: begin
        dq_oe  = 4'b1111;
        dq_out = sh_out[7:4];
      end
      default: ;
    endcase

    if (s_rise) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      sh_in    <= 7'd0;
      sh_out   <= 8'd0;
      op       <= 8'd0;
      addr     <= '0;
      wel      <= 1'b0;
      extra    <= 1'b0;
    end else if (s_rise) begin
      bit_cnt  <= 3'd0;
      byte_cnt <= 2'd0;
      extra    <= 1'b0;
      if (state == WDATA)
        wel <= 1'b0;
      else if (state == IGNORE && !extra && op == WREN)
        wel <= 1'b1;
      else if (state == IGNORE && !extra && op == WRDI)
        wel <= 1'b0;
    end else begin
      case (state)
        CMD: if (c_rise) begin
          sh_in   <= cmd_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) op <= cmd_byte;
        end
        // Shifting 24 bits through an AW-bit register keeps the low bits.
        ADDR: if (c_rise) begin
          addr    <= {addr[AW-2:0], dq0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            byte_cnt <= (byte_cnt == 2'd2) ? 2'd0 : byte_cnt + 2'd1;
        end
        DUMMY: if (c_rise) bit_cnt <= bit_cnt + 3'd1;
        WDATA: if (c_rise) begin
          sh_in   <= cmd_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) addr <= addr_page;
        end
        // Loading a byte also advances addr, so the RAM fetches the next
        // byte while this one shifts out.
        RDATA, STATUS, ID: if (c_fall) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd0) begin
            sh_out <= out_byte;
            if (state == RDATA) addr <= addr + AW'(1);
            if (state == ID && byte_cnt != 2'd3) byte_cnt <= byte_cnt + 2'd1;
          end else begin
            sh_out <= {sh_out[6:0], 1'b0};
          end
        end
        QDATA: if (c_fall) begin
          bit_cnt <= bit_cnt + 3'd1;
          if (!bit_cnt[0]) begin
            sh_out <= out_byte;
            addr   <= addr + AW'(1);
          end else begin
            sh_out <= {sh_out[3:0], 4'b0000};
          end
        end
        IGNORE: if (c_rise) extra <= 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_dq
    assign DQio[i] = dq_oe[i] ? dq_out[i] : 1'bz;
  end

endmodule

// File: tb/tb_qspi_flash_responder.sv
module tb_qspi_flash_responder;
  import qspi_pkg::*;

  localparam int DEPTH = 4096;
  localparam int AW    = 12;
  localparam int PH    = 5;   // clk cycles per C phase

  logic clk = 1'b0, reset = 1'b1, C = 1'b0, S = 1'b1;
  logic mosi = 1'b0, mosi_en = 1'b0;
  wire  [3:0] dq;

  assign dq[0] = mosi_en ? mosi : 1'bz;

  qspi_flash_responder #(.DEPTH(DEPTH), .JEDEC_ID(24'h20BA18)) dut (
    .clk   (clk),
    .reset (reset),
    .C     (C),
    .S     (S),
    .DQio  (dq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash model: byte array, WEL flag, ID bytes.
  logic [7:0] mmem [DEPTH];
  logic       mwel = 1'b0;
  logic [7:0] wbuf [8];
  logic [7:0] rx   [8];

  // Compare process: at every initiator sampling edge inside a command.
  logic       chk_en = 1'b0;
  logic [3:0] exp_oe = 4'b0, exp_mask = 4'b0, exp_dq = 4'b0;
  always @(posedge C) begin
    if (chk_en) begin
      check("dq_oe", {28'b0, dut.dq_oe}, {28'b0, exp_oe});
      if (exp_mask != 4'b0)
        check("dq_data", {28'b0, dq & exp_mask}, {28'b0, exp_dq & exp_mask});
    end
  end

  // One SPI clock: set MOSI, low phase, rising (sample), high phase, fall.
  task automatic slot(input logic d, input logic den, input logic [3:0] eoe,
                      input logic [3:0] emask, input logic [3:0] edq,
                      output logic [3:0] got);
    mosi = d; mosi_en = den;
    exp_oe = eoe; exp_mask = emask; exp_dq = edq; chk_en = 1'b1;
    repeat (PH) @(negedge clk);
    C = 1'b1;
    got = dq;
    repeat (PH) @(negedge clk);
    C = 1'b0;
    chk_en = 1'b0;
  endtask

  // Full transaction: opcode, optional address, dummies, nw write bytes,
  // part extra write bits, nrd read bytes; then model update.
  task automatic do_cmd(input logic [7:0] op, input logic [23:0] a,
                        input int nw, input int part, input int nrd);
    logic [3:0]  g, hi;
    logic [7:0]  eb [8];
    logic [23:0] idv;
    int          base;
    idv  = 24'h20BA18;
    base = int'(a[AW-1:0]);
    for (int i = 0; i < nrd; i++) begin
      if (op == READ || op == QOFR) eb[i] = mmem[(base + i) % DEPTH];
      else if (op == RDSR)          eb[i] = {6'b0, mwel, 1'b0};
      else if (op == RDID)          eb[i] = (i < 3) ? idv[8*(2-i) +: 8] : 8'h00;
      else                          eb[i] = 8'h00;
    end
    S = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 7; b >= 0; b--) slot(op[b], 1'b1, 4'b0, 4'b0, 4'b0, g);
    if (op == READ || op == QOFR || op == PP)
      for (int b = 23; b >= 0; b--) slot(a[b], 1'b1, 4'b0, 4'b0, 4'b0, g);
    if (op == QOFR)
      for (int k = 0; k < 8; k++) slot(1'b0, 1'b0, 4'b0, 4'b0, 4'b0, g);
    for (int i = 0; i < nw; i++)
      for (int b = 7; b >= 0; b--) slot(wbuf[i][b], 1'b1, 4'b0, 4'b0, 4'b0, g);
    for (int b = 0; b < part; b++) slot(wbuf[nw][7-b], 1'b1, 4'b0, 4'b0, 4'b0, g);
    for (int i = 0; i < nrd; i++) begin
      if (op == QOFR) begin
        slot(1'b0, 1'b0, 4'hF, 4'hF, eb[i][7:4], hi);
        slot(1'b0, 1'b0, 4'hF, 4'hF, eb[i][3:0], g);
        rx[i] = {hi, g};
      end else begin
        for (int b = 7; b >= 0; b--) begin
          slot(1'b0, 1'b1, 4'b0010, 4'b0010, {2'b00, eb[i][b], 1'b0}, g);
          rx[i] = {rx[i][6:0], g[1]};
        end
      end
    end
    repeat (PH) @(negedge clk);
    S = 1'b1; mosi_en = 1'b0;
    repeat (4) @(negedge clk);
    check("release_after_s", {28'b0, dut.dq_oe}, 32'h0);
    repeat (4) @(negedge clk);
    if ((op == WREN || op == WRDI) && nw == 0 && part == 0) mwel = (op == WREN);
    if (op == PP && mwel) begin
      for (int i = 0; i < nw; i++)
        mmem[(base & ~255) | ((base + i) & 255)] = wbuf[i];
      mwel = 1'b0;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    repeat (4) @(negedge clk);
    check("reset_oe", {28'b0, dut.dq_oe}, 32'h0);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Status after reset, WREN/WRDI
    do_cmd(RDSR, 24'h0, 0, 0, 1);  check("rdsr_reset", {24'b0, rx[0]}, 32'h00);
    do_cmd(WREN, 24'h0, 0, 0, 0);
    do_cmd(RDSR, 24'h0, 0, 0, 2);  check("rdsr_wren", {24'b0, rx[1]}, 32'h02);
    do_cmd(WRDI, 24'h0, 0, 0, 0);
    do_cmd(RDSR, 24'h0, 0, 0, 1);  check("rdsr_wrdi", {24'b0, rx[0]}, 32'h00);

    // Program and read back
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_cmd(PP, 24'h000010, 2, 0, 0);
    do_cmd(READ, 24'h000010, 0, 0, 2);
    check("read_10", {24'b0, rx[0]}, 32'hA5);
    check("read_11", {24'b0, rx[1]}, 32'h5A);
    do_cmd(RDSR, 24'h0, 0, 0, 1);  check("wel_after_pp", {24'b0, rx[0]}, 32'h00);

    // PP without WREN leaves memory alone
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'h77; do_cmd(PP, 24'h000020, 1, 0, 0);
    wbuf[0] = 8'h11; do_cmd(PP, 24'h000020, 1, 0, 0);
    do_cmd(READ, 24'h000020, 0, 0, 1); check("pp_no_wel", {24'b0, rx[0]}, 32'h77);

    // Page wrap on program
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'h01; wbuf[1] = 8'h02; do_cmd(PP, 24'h0000FF, 2, 0, 0);
    do_cmd(READ, 24'h0000FF, 0, 0, 1); check("page_ff", {24'b0, rx[0]}, 32'h01);
    do_cmd(READ, 24'h000000, 0, 0, 1); check("page_00", {24'b0, rx[0]}, 32'h02);

    // Quad output read
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'hC3; wbuf[1] = 8'h7E; do_cmd(PP, 24'h000100, 2, 0, 0);
    do_cmd(QOFR, 24'h000100, 0, 0, 2);
    check("quad_0", {24'b0, rx[0]}, 32'hC3);
    check("quad_1", {24'b0, rx[1]}, 32'h7E);

    // Read ID
    do_cmd(RDID, 24'h0, 0, 0, 4);
    check("id_0", {24'b0, rx[0]}, 32'h20);
    check("id_1", {24'b0, rx[1]}, 32'hBA);
    check("id_2", {24'b0, rx[2]}, 32'h18);
    check("id_3", {24'b0, rx[3]}, 32'h00);

    // Read wraps at DEPTH; upper address bits ignored
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'h9C; do_cmd(PP, 24'(DEPTH - 1), 1, 0, 0);
    do_cmd(READ, 24'(DEPTH - 1), 0, 0, 2);
    check("wrap_top", {24'b0, rx[0]}, 32'h9C);
    check("wrap_0",   {24'b0, rx[1]}, 32'h02);
    do_cmd(READ, 24'hABC010, 0, 0, 1); check("alias", {24'b0, rx[0]}, 32'hA5);

    // Partial byte abort: no write, WEL still cleared
    do_cmd(WREN, 24'h0, 0, 0, 0);
    wbuf[0] = 8'hF0; do_cmd(PP, 24'h000010, 0, 4, 0);
    do_cmd(READ, 24'h000010, 0, 0, 1); check("abort_nowrite", {24'b0, rx[0]}, 32'hA5);
    do_cmd(RDSR, 24'h0, 0, 0, 1); check("abort_wel", {24'b0, rx[0]}, 32'h00);

    // WREN with a trailing bit is rejected; unknown opcode keeps WEL
    wbuf[0] = 8'h80; do_cmd(WREN, 24'h0, 0, 1, 0);
    do_cmd(RDSR, 24'h0, 0, 0, 1); check("wren_9bits", {24'b0, rx[0]}, 32'h00);
    do_cmd(WREN, 24'h0, 0, 0, 0);
    do_cmd(8'hAB, 24'h0, 0, 0, 0);
    do_cmd(RDSR, 24'h0, 0, 0, 1); check("unknown_op", {24'b0, rx[0]}, 32'h02);

    // Reset in the middle of a READ
    S = 1'b0;
    repeat (4) @(negedge clk);
    for (int b = 7; b >= 0; b--) slot(READ[b], 1'b1, 4'b0, 4'b0, 4'b0, g);
    for (int b = 23; b >= 0; b--) slot(b == 4, 1'b1, 4'b0, 4'b0, 4'b0, g);
    for (int b = 7; b >= 5; b--)
      slot(1'b0, 1'b1, 4'b0010, 4'b0010, {2'b00, mmem[16][b], 1'b0}, g);
    reset = 1'b1;
    @(negedge clk);
    check("reset_mid_oe", {28'b0, dut.dq_oe}, 32'h0);
    reset = 1'b0; mwel = 1'b0;
    repeat (2) @(negedge clk);
    S = 1'b1; mosi_en = 1'b0;
    repeat (8) @(negedge clk);
    do_cmd(RDSR, 24'h0, 0, 0, 1); check("after_reset", {24'b0, rx[0]}, 32'h00);
    do_cmd(READ, 24'h000011, 0, 0, 1); check("after_reset_rd", {24'b0, rx[0]}, 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
